// File: rtl/filtro_iir_inverso_pkg.sv
// Shared constants for the filtro FIR / inverse-FIR pair.
package filtro_iir_inverso_pkg;

  // FIR coefficients c = [-1, 1/2, -1/4, 1/8], expressed in units of 1/8
  localparam int FIR_C0_Q3    = -8;
  localparam int FIR_C1_Q3    = 4;
  localparam int FIR_C2_Q3    = -2;
  localparam int FIR_C3_Q3    = 1;
  // FIR output scale 1/2
  localparam int FIR_SCALE_SH = 1;

  // Inverse recurrence in 1/8 units: -16*y + 4*x1 - 2*x2 + x3, then >>> 3
  localparam int INV_SH_Y     = 4;
  localparam int INV_SH_X1    = 2;
  localparam int INV_SH_X2    = 1;
  localparam int INV_FRAC     = 3;

  // Accumulator wide enough that no partial sum can overflow
  function automatic int acc_width(input int wi, input int wo);
    return ((wi + 5) > (wo + 4)) ? (wi + 5) : (wo + 4);
  endfunction

endpackage

// File: rtl/filtro_iir_inverso_sat_trunc.sv
// Signed saturating narrower: clamps IN_W-bit value into OUT_W-bit range.
module filtro_iir_inverso_sat_trunc #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_val,
  output logic [OUT_W-1:0] o_val,
  output logic             o_ovf
);

  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] top_bits;

  // in range only when all bits above the output sign bit copy the sign
  always_comb begin
    top_bits = i_val[IN_W-1:OUT_W-1];
    o_ovf    = ~((&top_bits) | ~(|top_bits));
    o_val    = i_val[OUT_W-1:0];
    if (o_ovf) o_val = i_val[IN_W-1] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/filtro_iir_inverso.sv
// Inverse filter for the 4-tap filtro FIR: recovers x[n] from y[n] with a
// 3-tap recursion, single registered output stage and full handshakes.
module filtro_iir_inverso
  import filtro_iir_inverso_pkg::*;
#(
  parameter int WW_INPUT  = 8,
  parameter int WW_OUTPUT = 8
) (
  input  logic                 clk,
  input  logic                 i_srst,
  input  logic                 i_en,
  input  logic [WW_INPUT-1:0]  i_is_data,
  input  logic                 i_is_dv,
  output logic                 o_is_rfd,
  output logic [WW_OUTPUT-1:0] o_os_data,
  output logic                 o_os_dv,
  input  logic                 i_os_rfd,
  output logic                 o_sat
);

  localparam int ACC_W = acc_width(WW_INPUT, WW_OUTPUT);

  logic [WW_OUTPUT-1:0]    x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, out_q, out_d;
  logic                    dv_q, dv_d, sat_q, sat_d;
  logic signed [ACC_W-1:0] y_ext, x1_ext, x2_ext, x3_ext, acc, acc_sh;
  logic [WW_OUTPUT-1:0]    x_new;
  logic                    ovf, acc_in, xfer_out;

  // accept when the output register is empty or draining this cycle
  assign o_is_rfd  = i_en & (~dv_q | i_os_rfd);
  assign o_os_dv   = dv_q & i_en;
  assign o_os_data = out_q;
  assign o_sat     = sat_q & i_en;
  assign acc_in    = i_is_dv & o_is_rfd;
  assign xfer_out  = o_os_dv & i_os_rfd;

  // recurrence in 1/8 units, then floor back to integer scale
  always_comb begin
    y_ext  = {{(ACC_W-WW_INPUT){i_is_data[WW_INPUT-1]}}, i_is_data};
    x1_ext = {{(ACC_W-WW_OUTPUT){x1_q[WW_OUTPUT-1]}}, x1_q};
    x2_ext = {{(ACC_W-WW_OUTPUT){x2_q[WW_OUTPUT-1]}}, x2_q};
    x3_ext = {{(ACC_W-WW_OUTPUT){x3_q[WW_OUTPUT-1]}}, x3_q};
    acc    = (x1_ext <<< INV_SH_X1) - (x2_ext <<< INV_SH_X2) + x3_ext
           - (y_ext <<< INV_SH_Y);
    acc_sh = acc >>> INV_FRAC;
  end

  filtro_iir_inverso_sat_trunc #(
    .IN_W  (ACC_W),
    .OUT_W (WW_OUTPUT)
  ) u_sat (
    .i_val (acc_sh),
    .o_val (x_new),
    .o_ovf (ovf)
  );

  // next state: load on accept (history keeps saturated values), drain on transfer
  always_comb begin
    x1_d  = x1_q;
    x2_d  = x2_q;
    x3_d  = x3_q;
    out_d = out_q;
    dv_d  = dv_q;
    sat_d = 1'b0;
    if (acc_in) begin
      out_d = x_new;
      dv_d  = 1'b1;
      x3_d  = x2_q;
      x2_d  = x1_q;
      x1_d  = x_new;
      sat_d = ovf;
    end else if (xfer_out) begin
      dv_d  = 1'b0;
    end
  end

  // state registers; reset wins over enable and handshakes
  always_ff @(posedge clk) begin
    if (i_srst) begin
      x1_q  <= '0;
      x2_q  <= '0;
      x3_q  <= '0;
      out_q <= '0;
      dv_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      x3_q  <= x3_d;
      out_q <= out_d;
      dv_q  <= dv_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_filtro_iir_inverso.sv
// Scoreboard bench for filtro_iir_inverso: driver pushes expected samples,
// monitor pops them on every output transfer.
module tb_filtro_iir_inverso;

  logic       clk = 1'b0;
  logic       i_srst, i_en, i_is_dv, o_is_rfd, o_os_dv, i_os_rfd, o_sat;
  logic [7:0] i_is_data, o_os_data;

  always #5 clk = ~clk;

  filtro_iir_inverso #(.WW_INPUT(8), .WW_OUTPUT(8)) dut (
    .clk       (clk),
    .i_srst    (i_srst),
    .i_en      (i_en),
    .i_is_data (i_is_data),
    .i_is_dv   (i_is_dv),
    .o_is_rfd  (o_is_rfd),
    .o_os_data (o_os_data),
    .o_os_dv   (o_os_dv),
    .i_os_rfd  (i_os_rfd),
    .o_sat     (o_sat)
  );

  int n_cmp = 0, n_err = 0;
  int exp_q[$];
  int hist[3];      // reference model: last three emitted x (saturated)
  int fx[3];        // FIR side: last three original x
  int nxt_y = 0, rfd_pct = 100, en_pct = 100, ov_val = 0, acc_cnt = 0;
  bit nxt_dv = 0, nxt_srst = 0, ov_on = 0, last_acc = 0;
  bit sat_pend = 0, sat_exp = 0, prev_srst = 0, checks_on = 0;
  bit held = 0;
  int held_val = 0;

  function automatic void chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // x[n] = sat(floor((-16y + 4x1 - 2x2 + x3) / 8))
  function automatic int model(input int y, output bit s);
    int acc, x;
    acc = -16 * y + 4 * hist[0] - 2 * hist[1] + hist[2];
    x   = acc >>> 3;
    s   = 1'b0;
    if (x > 127)  begin x = 127;  s = 1'b1; end
    if (x < -128) begin x = -128; s = 1'b1; end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
    return x;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    i_srst    = nxt_srst;
    i_is_dv   = nxt_dv;
    i_is_data = 8'(nxt_y);
    i_os_rfd  = ($urandom_range(99) < rfd_pct);
    i_en      = ($urandom_range(99) < en_pct);
    @(negedge clk);
    last_acc = 0;
    if (checks_on) begin
      chk("o_sat", o_sat, (sat_pend && i_en) ? sat_exp : 0);
      if (prev_srst) begin
        chk("rst_dv", o_os_dv, 0);
        chk("rst_data", o_os_data, 0);
        chk("rst_rfd", o_is_rfd, i_en);
      end
      if (!i_en) begin
        chk("off_rfd", o_is_rfd, 0);
        chk("off_dv", o_os_dv, 0);
      end else if (o_os_dv && !i_os_rfd) begin
        chk("stall_rfd", o_is_rfd, 0);
      end
    end
    sat_pend = 0;
    if (i_srst) begin
      exp_q.delete();
      hist = '{0, 0, 0};
      fx   = '{0, 0, 0};
    end else if (i_is_dv && o_is_rfd) begin
      bit s;
      int x;
      x = model(nxt_y, s);
      exp_q.push_back(ov_on ? ov_val : x);
      sat_pend = 1;
      sat_exp  = s;
      last_acc = 1;
      acc_cnt++;
    end
    prev_srst = i_srst;
  endtask

  task automatic send(input int y, input bit ov = 0, input int ovx = 0);
    nxt_dv = 1; nxt_y = y; ov_on = ov; ov_val = ovx;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    nxt_dv = 0; ov_on = 0;
  endtask

  task automatic do_reset();
    nxt_srst = 1;
    cycle();
    nxt_srst = 0;
  endtask

  // monitor: compare on each output transfer; check stability while stalled
  always @(negedge clk) begin
    if (checks_on && !i_srst) begin
      if (held && o_os_dv) chk("stall_hold", $signed(o_os_data), held_val);
      if (o_os_dv && i_os_rfd) begin
        held = 0;
        if (exp_q.size() == 0) chk("unexpected_out", $signed(o_os_data), 999);
        else chk("o_os_data", $signed(o_os_data), exp_q.pop_front());
      end else if (o_os_dv && !i_os_rfd) begin
        held = 1;
        held_val = $signed(o_os_data);
      end
    end
    if (i_srst) held = 0;
  end

  initial begin
    int a0, y, x0;
    i_srst = 1; i_en = 1; i_is_dv = 0; i_is_data = 0; i_os_rfd = 1;
    do_reset();
    checks_on = 1;

    // reset while data is offered, then 0 -> 0
    nxt_dv = 1; nxt_y = 55;
    do_reset();
    nxt_dv = 0;
    send(0, 1, 0);

    // impulse recovery, back-to-back
    send(-32, 1, 64);
    send(16, 1, 0);
    send(-8, 1, 0);
    send(4, 1, 0);
    send(0, 1, 0);

    // saturation then decay from saturated history
    do_reset();
    send(-100, 1, 127);
    send(0, 1, 63);

    // backpressure: one accept, then stall for 3 cycles
    cycle();
    rfd_pct = 0;
    send(10);
    a0 = acc_cnt;
    nxt_dv = 1; nxt_y = 20;
    repeat (3) cycle();
    chk("bp_accepts", acc_cnt - a0, 0);
    rfd_pct = 100;
    send(20);
    send(30);

    // enable freeze mid-stream
    send(5);
    en_pct = 0;
    nxt_dv = 1; nxt_y = 7;
    repeat (2) cycle();
    en_pct = 100;
    send(7);
    send(9);

    // random y with random gaps, stalls, enable drops and occasional reset
    rfd_pct = 70; en_pct = 90;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(2)) cycle();
      if ($urandom_range(99) == 0) do_reset();
      send(int'($urandom_range(255)) - 128);
    end

    // round trip: x -> FIR -> inverse must give x back
    do_reset();
    for (int i = 0; i < 200; i++) begin
      x0 = (int'($urandom_range(15)) - 8) * 16;
      y  = (-8 * x0 + 4 * fx[0] - 2 * fx[1] + fx[2]) / 16;
      fx[2] = fx[1]; fx[1] = fx[0]; fx[0] = x0;
      repeat ($urandom_range(2)) cycle();
      send(y, 1, x0);
    end

    rfd_pct = 100; en_pct = 100;
    repeat (5) cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
